// File: rtl/rgb_cmd_sequencer.sv
// rgb_cmd_sequencer
//   Queues colour commands arriving as ASCII bytes from a UART receiver and
//   plays them out on an RGB LED. Each dequeued colour is held for
//   DWELL_CYCLES clocks. The last colour stays lit after the queue drains.
//
// Ports
//   clock      in   1      system clock, rising edge
//   reset      in   1      synchronous, active-high
//   rx_data    in   8      received byte, qualified by rx_valid
//   rx_valid   in   1      one-cycle strobe per received byte
//   rgb        out  3      LED drive [2]=R [1]=G [0]=B, active-high
//   busy       out  1      high while a dwell period is running
//   fifo_count out  CW     commands waiting (not yet displayed)
//   overflow   out  1      sticky: a colour command was dropped on a full queue
//
// state | meaning
// IDLE  | no dwell running; rgb holds the last colour; pops as soon as queue is non-empty
// DWELL | colour on display; counter runs down to 0, then next pop or back to IDLE
module rgb_cmd_sequencer #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 26,
    localparam int PTR_W       = $clog2(FIFO_DEPTH),
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [2:0]    rgb,
    output logic          busy,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]    FULL   = CW'(FIFO_DEPTH);

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [2:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               is_color;
    logic [2:0]         color;
    logic               clear;
    logic               pop;
    logic               push;
    logic               drop;

    always_comb begin
        is_color = 1'b0;
        color    = 3'b000;
        unique case (rx_data)
            8'h52: begin is_color = 1'b1; color = 3'b100; end
            8'h47: begin is_color = 1'b1; color = 3'b010; end
            8'h42: begin is_color = 1'b1; color = 3'b001; end
            8'h57: begin is_color = 1'b1; color = 3'b111; end
            8'h4F: begin is_color = 1'b1; color = 3'b000; end
            default: ;
        endcase
    end

    assign clear = rx_valid && (rx_data == 8'h43);
    // A pop happens whenever the display is free to take the next colour.
    assign pop   = (fifo_count != '0) && ((state == IDLE) || (counter == '0));
    // A full queue still accepts a push when the head leaves the same cycle.
    assign push  = rx_valid && is_color && ((fifo_count != FULL) || pop);
    assign drop  = rx_valid && is_color && !push;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state      <= IDLE;
            counter    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rgb        <= 3'b000;
            busy       <= 1'b0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= color;
                wr_ptr      <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rgb     <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
                counter <= RELOAD;
                state   <= DWELL;
                busy    <= 1'b1;
            end else if (state == DWELL) begin
                if (counter == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    counter <= counter - 1'b1;
                end
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rgb_cmd_sequencer.sv
module tb_rgb_cmd_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rgb;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    rgb_cmd_sequencer #(
        .DWELL_CYCLES(8),
        .FIFO_DEPTH  (4),
        .CNT_W       (26)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rgb       (rgb),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; afterwards we sit 1 time unit into the new cycle.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present a byte for one cycle; returns one cycle later.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_rgb, input logic e_busy,
                             input logic [2:0] e_cnt, input logic e_ovf);
        check({tag, ".rgb"},   {5'b0, rgb},        {5'b0, e_rgb});
        check({tag, ".busy"},  {7'b0, busy},       {7'b0, e_busy});
        check({tag, ".count"}, {5'b0, fifo_count}, {5'b0, e_cnt});
        check({tag, ".ovf"},   {7'b0, overflow},   {7'b0, e_ovf});
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tick(2);
        reset = 1'b0;
        check_all("reset", 3'b000, 1'b0, 3'd0, 1'b0);

        // Single 'R' at cycle 0
        send(8'h52);                                 // cycle 1
        check_all("r_c1", 3'b000, 1'b0, 3'd1, 1'b0);
        tick(1);                                     // cycle 2
        check_all("r_c2", 3'b100, 1'b1, 3'd0, 1'b0);
        tick(7);                                     // cycle 9
        check("r_c9.busy", {7'b0, busy}, 8'd1);
        tick(1);                                     // cycle 10
        check_all("r_c10", 3'b100, 1'b0, 3'd0, 1'b0);

        // 'R','G','B' on cycles 0,1,2
        send(8'h52);                                 // cycle 1
        send(8'h47);                                 // cycle 2
        check_all("rgb_c2", 3'b100, 1'b1, 3'd1, 1'b0);
        send(8'h42);                                 // cycle 3
        check_all("rgb_c3", 3'b100, 1'b1, 3'd2, 1'b0);
        tick(6);                                     // cycle 9
        check("rgb_c9.rgb", {5'b0, rgb}, 8'h04);
        tick(1);                                     // cycle 10
        check_all("rgb_c10", 3'b010, 1'b1, 3'd1, 1'b0);
        tick(7);                                     // cycle 17
        check("rgb_c17.rgb", {5'b0, rgb}, 8'h02);
        tick(1);                                     // cycle 18
        check_all("rgb_c18", 3'b001, 1'b1, 3'd0, 1'b0);
        tick(7);                                     // cycle 25
        check("rgb_c25.busy", {7'b0, busy}, 8'd1);
        tick(1);                                     // cycle 26
        check_all("rgb_c26", 3'b001, 1'b0, 3'd0, 1'b0);

        // Overflow: 'R' then five more colours during the first dwell
        send(8'h52);                                 // cycle 1
        tick(1);                                     // cycle 2, dwell R
        send(8'h47);
        send(8'h42);
        send(8'h57);
        send(8'h47);
        send(8'h42);                                 // cycle 7, dropped
        check_all("ovf_c7", 3'b100, 1'b1, 3'd4, 1'b1);
        tick(3);                                     // cycle 10
        check_all("ovf_c10", 3'b010, 1'b1, 3'd3, 1'b1);
        tick(8);                                     // cycle 18
        check_all("ovf_c18", 3'b001, 1'b1, 3'd2, 1'b1);
        tick(8);                                     // cycle 26
        check_all("ovf_c26", 3'b111, 1'b1, 3'd1, 1'b1);
        tick(8);                                     // cycle 34
        check_all("ovf_c34", 3'b010, 1'b1, 3'd0, 1'b1);
        tick(8);                                     // cycle 42
        check_all("ovf_c42", 3'b010, 1'b0, 3'd0, 1'b1);

        // Clear mid-dwell with two queued
        send(8'h52);
        tick(1);
        send(8'h47);
        send(8'h42);
        check_all("clr_pre", 3'b100, 1'b1, 3'd2, 1'b1);
        send(8'h43);
        check_all("clr_post", 3'b000, 1'b0, 3'd0, 1'b0);
        tick(20);
        check_all("clr_late", 3'b000, 1'b0, 3'd0, 1'b0);

        // Ignored bytes, then 'W' and 'O'
        send(8'h00);
        check_all("ign_00", 3'b000, 1'b0, 3'd0, 1'b0);
        send(8'h78);
        check_all("ign_x", 3'b000, 1'b0, 3'd0, 1'b0);
        send(8'h72);
        check_all("ign_r", 3'b000, 1'b0, 3'd0, 1'b0);
        send(8'h57);
        tick(1);
        check_all("w_on", 3'b111, 1'b1, 3'd0, 1'b0);
        send(8'h78);                                 // ignored during dwell
        check_all("w_ign", 3'b111, 1'b1, 3'd0, 1'b0);
        tick(8);
        check_all("w_done", 3'b111, 1'b0, 3'd0, 1'b0);
        send(8'h4F);
        tick(1);
        check_all("o_on", 3'b000, 1'b1, 3'd0, 1'b0);
        tick(8);

        // Reset mid-dwell with three queued
        send(8'h52);
        tick(1);
        send(8'h47);
        send(8'h42);
        send(8'h57);
        check_all("rst_pre", 3'b100, 1'b1, 3'd3, 1'b0);
        reset = 1'b1;
        tick(1);
        check_all("rst_on", 3'b000, 1'b0, 3'd0, 1'b0);
        reset = 1'b0;
        tick(20);
        check_all("rst_late", 3'b000, 1'b0, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
